// File: rtl/r500_pkg.sv
// Shared R500 definitions: perf-counter FSM states and the store-path
// addresses that select each counter.
package r500_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [15:0] CLK_CYCLE_ADDR            = 16'h4F00;
   localparam logic [15:0] INVALID_CLK_CYCLE_ADDR    = 16'h4F04;
   localparam logic [15:0] RETIRED_INSTRUCTIONS_ADDR = 16'h4F08;
   localparam logic [15:0] CORRECT_PREDICTIONS_ADDR  = 16'h4F0C;
   localparam logic [15:0] TOTAL_PREDICTIONS_ADDR    = 16'h4F10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
// sat_hit flags an increment that was blocked because the count is full.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             sat_hit
);

   logic full;

   assign full    = (count == '1);
   assign sat_hit = inc && full && !clear;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (inc && !full) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/perf_counters.sv
// R500 performance-counter unit: IDLE/RUN/DONE run tracking, five
// saturating event counters and a sticky overflow flag.
module perf_counters
   import r500_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt,
   input  logic             clear,
   input  logic             retire_valid,
   input  logic             branch_resolved,
   input  logic             branch_correct,
   output logic [WIDTH-1:0] clk_cycles,
   output logic [WIDTH-1:0] invalid_clk_cycles,
   output logic [WIDTH-1:0] retired_instructions,
   output logic [WIDTH-1:0] correct_predictions,
   output logic [WIDTH-1:0] total_predictions,
   output logic             running,
   output logic             done,
   output logic             overflow
);

   state_t     state_q;
   state_t     state_d;
   logic       counting;
   logic [4:0] inc;
   logic [4:0] hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (halt)  state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign running  = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign counting = running;

   // The halt cycle is still RUN in the register, so its events count.
   assign inc[0] = counting;
   assign inc[1] = counting && !retire_valid;
   assign inc[2] = counting && retire_valid;
   assign inc[3] = counting && branch_resolved && branch_correct;
   assign inc[4] = counting && branch_resolved;

   sat_counter #(.WIDTH(WIDTH)) u_clk_cycles (
      .clk(clk), .rst_n(rst_n), .clear(clear), .inc(inc[0]),
      .count(clk_cycles), .sat_hit(hit[0])
   );

   sat_counter #(.WIDTH(WIDTH)) u_invalid_clk_cycles (
      .clk(clk), .rst_n(rst_n), .clear(clear), .inc(inc[1]),
      .count(invalid_clk_cycles), .sat_hit(hit[1])
   );

   sat_counter #(.WIDTH(WIDTH)) u_retired_instructions (
      .clk(clk), .rst_n(rst_n), .clear(clear), .inc(inc[2]),
      .count(retired_instructions), .sat_hit(hit[2])
   );

   sat_counter #(.WIDTH(WIDTH)) u_correct_predictions (
      .clk(clk), .rst_n(rst_n), .clear(clear), .inc(inc[3]),
      .count(correct_predictions), .sat_hit(hit[3])
   );

   sat_counter #(.WIDTH(WIDTH)) u_total_predictions (
      .clk(clk), .rst_n(rst_n), .clear(clear), .inc(inc[4]),
      .count(total_predictions), .sat_hit(hit[4])
   );

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         overflow <= 1'b0;
      end else if (|hit) begin
         overflow <= 1'b1;
      end
   end

endmodule

// File: doc/perf_counters.md
# perf_counters

Performance-counter unit for the R500 core. It accumulates total cycles, non-retiring cycles, retired instructions, correct branch predictions and total branch predictions over one program run. It freezes the counts when the program halts. Its five 32-bit outputs feed the store path directly: a store to 0x4F00/0x4F04/0x4F08/0x4F0C/0x4F10 writes the corresponding count into data memory instead of rs2.

## Interface
Parameters:
- WIDTH, 32, counter width; all count outputs are WIDTH bits.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  level/pulse; begin a run (first fetch of the program).
- halt  in  1  pulse; halting instruction retires this cycle.
- clear  in  1  pulse; zero all counters and return to IDLE.
- retire_valid  in  1  an instruction retires this cycle.
- branch_resolved  in  1  a predicted control-transfer resolves this cycle.
- branch_correct  in  1  the resolving prediction was correct; qualified by branch_resolved.
- clk_cycles  out  WIDTH  cycles spent in RUN.
- invalid_clk_cycles  out  WIDTH  RUN cycles with retire_valid low.
- retired_instructions  out  WIDTH  RUN cycles with retire_valid high.
- correct_predictions  out  WIDTH  RUN cycles with branch_resolved and branch_correct high.
- total_predictions  out  WIDTH  RUN cycles with branch_resolved high.
- running  out  1  state == RUN.
- done  out  1  state == DONE; counts frozen and coherent.
- overflow  out  1  sticky; any counter saturated since last clear/reset.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on halt.
  - DONE -> IDLE on clear.
  - Any state -> IDLE on clear.
  - All other inputs leave the state unchanged.
- Priority: !rst_n > clear > halt > start.
  - start in RUN or DONE is ignored.
  - halt in IDLE or DONE is ignored.
  - start and halt together in IDLE: go to RUN, and that cycle is not counted.
- Counting happens only in cycles where the registered state is RUN. This includes the cycle in which halt is sampled: its cycle, retire and branch events are counted, and the counts are frozen from the next cycle.
- Per counted cycle:
  - clk_cycles += 1.
  - Exactly one of retired_instructions or invalid_clk_cycles += 1, selected by retire_valid.
  - If branch_resolved: total_predictions += 1, and if branch_correct also high, correct_predictions += 1.
- branch_correct without branch_resolved is ignored.
- Saturation: each counter stops at 2^WIDTH-1 and never wraps; the first saturating increment sets overflow.
- Invariants while overflow is low:
  - clk_cycles == retired_instructions + invalid_clk_cycles.
  - correct_predictions <= total_predictions.
- clear zeroes all counters and overflow in the same cycle it is sampled. It overrides any same-cycle increment.

## Timing
- All outputs are registered; an event sampled at edge N is visible after edge N.
- Reset values: all counters 0, overflow 0, state IDLE, running 0, done 0.
- Reset mid-run behaves identically to clear, with no partial update.
- running and done are decoded from the state register and change on the same edge as the transition.
- No handshake: the store path reads the counters combinationally. Software reads them after done for coherent values; reads during RUN return the count as of the previous edge.

## Structure
- Shared package r500_pkg holds:
  - the state enum (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the counter address constants (CLK_CYCLE_ADDR 0x4F00 through TOTAL_PREDICTIONS_ADDR 0x4F10), shared with the store and load paths.
- Sub-module sat_counter: synchronous active-low reset, clear, inc, WIDTH-bit saturating count, 1-cycle sat_hit pulse. Instantiated five times.
- Top level holds the FSM, the per-counter increment qualification, and the overflow OR-latch.

## Test plan
- Reset, then start, then 10 cycles with retire_valid alternating 1,0, then halt on cycle 10 with retire_valid=1 -> clk_cycles=10, retired=6, invalid=4, done=1. Values stay constant for 20 further cycles of toggling inputs.
- 8 cycles in RUN with branch_resolved=1 and branch_correct=1,1,0,1,0,0,1,1 -> total_predictions=8, correct_predictions=5. branch_correct=1 with branch_resolved=0 -> no change.
- clear and halt in the same RUN cycle -> next cycle all counters 0, state IDLE. start and halt together in IDLE -> RUN, counters still 0.
- Force retired_instructions to 0xFFFFFFFE, then 3 retiring cycles -> value holds at 0xFFFFFFFF, overflow=1 until clear.
- rst_n low for one cycle mid-RUN with counts at 37 -> all outputs 0 and IDLE after that edge. Following start counts from 0.
- halt in IDLE, start in DONE -> no state change, no counting.
